conv_seq_cu: RTL and testbench

CONV_SEQ_CU -- requirements
Module: conv_seq_cu

---
 rtl/conv_seq_pkg.sv | 29 ++
 rtl/conv_win_addr.sv | 105 ++++++++++
 rtl/conv_seq_cu.sv | 160 ++++++++++++++++
 tb/tb_conv_seq_cu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and geometry helpers for the convolution sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_NEXT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int calc_ofm(int ifm_size, int kernal_size, int stride, int padding);
        return (ifm_size + 2 * padding - kernal_size) / stride + 1;
    endfunction

    function automatic int calc_groups(int filters, int units);
        return (filters + units - 1) / units;
    endfunction

    function automatic int calc_elems(int depth, int kernal_size);
        return depth * kernal_size * kernal_size;
    endfunction

    // Address/counter width for n distinct values; never narrower than one bit.
    function automatic int addr_w(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_win_addr.sv
// Nested window counters (g, r, c, d, kr, kc) with padding check and
// IFM / weight / bias / OFM address generation for the current element.
module conv_win_addr
    import conv_seq_pkg::*;
#(
    parameter int IFM_SIZE          = 9,
    parameter int IFM_DEPTH         = 28,
    parameter int KERNAL_SIZE       = 5,
    parameter int STRIDE            = 1,
    parameter int PADDING           = 0,
    parameter int NUMBER_OF_FILTERS = 88,
    parameter int NUMBER_OF_UNITS   = 11,
    localparam int OFM    = calc_ofm(IFM_SIZE, KERNAL_SIZE, STRIDE, PADDING),
    localparam int GROUPS = calc_groups(NUMBER_OF_FILTERS, NUMBER_OF_UNITS),
    localparam int ELEMS  = calc_elems(IFM_DEPTH, KERNAL_SIZE),
    localparam int IFM_AW = addr_w(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
    localparam int WM_AW  = addr_w(GROUPS * ELEMS),
    localparam int BM_AW  = addr_w(GROUPS),
    localparam int OFM_AW = addr_w(GROUPS * OFM * OFM)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_step,
    output logic              o_pad,
    output logic [IFM_AW-1:0] o_ifm_addr,
    output logic [WM_AW-1:0]  o_wm_addr,
    output logic [BM_AW-1:0]  o_bm_addr,
    output logic [OFM_AW-1:0] o_ofm_addr,
    output logic              o_first_win,
    output logic              o_last_win,
    output logic              o_last_elem,
    output logic              o_last_group
);

    localparam int KW = addr_w(KERNAL_SIZE);
    localparam int DW = addr_w(IFM_DEPTH);
    localparam int OW = addr_w(OFM);
    localparam int GW = addr_w(GROUPS);

    logic [GW-1:0] r_g;
    logic [OW-1:0] r_r;
    logic [OW-1:0] r_c;
    logic [DW-1:0] r_d;
    logic [KW-1:0] r_kr;
    logic [KW-1:0] r_kc;

    logic w_kc_last, w_kr_last, w_d_last, w_c_last, w_r_last, w_g_last;
    int   w_y, w_x;

    assign w_kc_last = (int'(r_kc) == KERNAL_SIZE - 1);
    assign w_kr_last = (int'(r_kr) == KERNAL_SIZE - 1);
    assign w_d_last  = (int'(r_d)  == IFM_DEPTH - 1);
    assign w_c_last  = (int'(r_c)  == OFM - 1);
    assign w_r_last  = (int'(r_r)  == OFM - 1);
    assign w_g_last  = (int'(r_g)  == GROUPS - 1);

    assign o_last_win   = w_d_last & w_kr_last & w_kc_last;
    assign o_last_elem  = o_last_win & w_c_last & w_r_last & w_g_last;
    assign o_last_group = w_g_last;
    assign o_first_win  = (r_d == '0) && (r_kr == '0) && (r_kc == '0);

    // Signed input coordinates: negative or >= IFM_SIZE means the zero border.
    assign w_y   = int'(r_r) * STRIDE + int'(r_kr) - PADDING;
    assign w_x   = int'(r_c) * STRIDE + int'(r_kc) - PADDING;
    assign o_pad = (w_y < 0) || (w_y >= IFM_SIZE) || (w_x < 0) || (w_x >= IFM_SIZE);

    assign o_ifm_addr = o_pad ? '0
                      : IFM_AW'(int'(r_d) * IFM_SIZE * IFM_SIZE + w_y * IFM_SIZE + w_x);
    assign o_wm_addr  = WM_AW'(int'(r_g) * ELEMS + int'(r_d) * KERNAL_SIZE * KERNAL_SIZE
                             + int'(r_kr) * KERNAL_SIZE + int'(r_kc));
    assign o_bm_addr  = BM_AW'(r_g);
    assign o_ofm_addr = OFM_AW'(int'(r_g) * OFM * OFM + int'(r_r) * OFM + int'(r_c));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_g  <= '0;
            r_r  <= '0;
            r_c  <= '0;
            r_d  <= '0;
            r_kr <= '0;
            r_kc <= '0;
        end else if (i_clear) begin
            r_g  <= '0;
            r_r  <= '0;
            r_c  <= '0;
            r_d  <= '0;
            r_kr <= '0;
            r_kc <= '0;
        end else if (i_step) begin
            r_kc <= w_kc_last ? '0 : r_kc + 1'b1;
            if (w_kc_last)
                r_kr <= w_kr_last ? '0 : r_kr + 1'b1;
            if (w_kc_last && w_kr_last)
                r_d <= w_d_last ? '0 : r_d + 1'b1;
            if (o_last_win)
                r_c <= w_c_last ? '0 : r_c + 1'b1;
            if (o_last_win && w_c_last)
                r_r <= w_r_last ? '0 : r_r + 1'b1;
            if (o_last_win && w_c_last && w_r_last)
                r_g <= w_g_last ? '0 : r_g + 1'b1;
        end
    end

endmodule

// File: rtl/conv_seq_cu.sv
// Convolution layer sequencer: layer handshakes, run FSM, and the strobe
// delay line that aligns conv/accu/relu/write with one-cycle memory reads.
module conv_seq_cu
    import conv_seq_pkg::*;
#(
    parameter int IFM_SIZE          = 9,
    parameter int IFM_DEPTH         = 28,
    parameter int KERNAL_SIZE       = 5,
    parameter int STRIDE            = 1,
    parameter int PADDING           = 0,
    parameter int NUMBER_OF_FILTERS = 88,
    parameter int NUMBER_OF_UNITS   = 11,
    localparam int OFM    = calc_ofm(IFM_SIZE, KERNAL_SIZE, STRIDE, PADDING),
    localparam int GROUPS = calc_groups(NUMBER_OF_FILTERS, NUMBER_OF_UNITS),
    localparam int ELEMS  = calc_elems(IFM_DEPTH, KERNAL_SIZE),
    localparam int IFM_AW = addr_w(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
    localparam int WM_AW  = addr_w(GROUPS * ELEMS),
    localparam int BM_AW  = addr_w(GROUPS),
    localparam int OFM_AW = addr_w(GROUPS * OFM * OFM)
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_from_previous,
    input  logic                       end_from_next,
    output logic                       end_to_previous,
    output logic                       start_to_next,
    output logic                       busy,
    output logic                       ifm_enable_read,
    output logic [IFM_AW-1:0]          ifm_address_read,
    output logic                       pad_zero,
    output logic                       wm_enable_read,
    output logic [WM_AW-1:0]           wm_address_read,
    output logic                       bm_enable_read,
    output logic [BM_AW-1:0]           bm_address_read,
    output logic                       conv_enable,
    output logic                       accu_enable,
    output logic                       relu_enable,
    output logic                       ofm_enable_write,
    output logic [OFM_AW-1:0]          ofm_address_write,
    output logic [NUMBER_OF_UNITS-1:0] ofm_unit_valid
);

    localparam int LAST_UNITS = NUMBER_OF_FILTERS - (GROUPS - 1) * NUMBER_OF_UNITS;

    state_t r_state;
    logic   r_drain, r_pending, r_next_busy;
    logic   r_end_to_previous, r_start_to_next;
    logic   r_conv_en, r_pad_zero, r_accu_en, r_relu_en, r_ofm_we;
    logic [OFM_AW-1:0]          r_acc_ofm_addr, r_ofm_addr;
    logic [NUMBER_OF_UNITS-1:0] r_acc_valid, r_ofm_valid;

    logic w_issue, w_pad, w_first_win, w_last_win, w_last_elem, w_last_group, w_next_busy;
    logic [IFM_AW-1:0]          w_ifm_addr;
    logic [WM_AW-1:0]           w_wm_addr;
    logic [BM_AW-1:0]           w_bm_addr;
    logic [OFM_AW-1:0]          w_ofm_addr;
    logic [NUMBER_OF_UNITS-1:0] w_unit_valid;

    assign w_issue = (r_state == RUN);
    // A release arriving this cycle lets a waiting run start without an extra idle cycle.
    assign w_next_busy = r_next_busy & ~end_from_next;

    conv_win_addr #(
        .IFM_SIZE(IFM_SIZE), .IFM_DEPTH(IFM_DEPTH), .KERNAL_SIZE(KERNAL_SIZE),
        .STRIDE(STRIDE), .PADDING(PADDING),
        .NUMBER_OF_FILTERS(NUMBER_OF_FILTERS), .NUMBER_OF_UNITS(NUMBER_OF_UNITS)
    ) u_win_addr (
        .clk(clk), .reset(reset), .i_clear(~w_issue), .i_step(w_issue),
        .o_pad(w_pad), .o_ifm_addr(w_ifm_addr), .o_wm_addr(w_wm_addr),
        .o_bm_addr(w_bm_addr), .o_ofm_addr(w_ofm_addr), .o_first_win(w_first_win),
        .o_last_win(w_last_win), .o_last_elem(w_last_elem), .o_last_group(w_last_group)
    );

    for (genvar gi = 0; gi < NUMBER_OF_UNITS; gi++) begin : g_unit_valid
        assign w_unit_valid[gi] = !w_last_group || (gi < LAST_UNITS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_drain           <= 1'b0;
            r_pending         <= 1'b0;
            r_next_busy       <= 1'b0;
            r_end_to_previous <= 1'b0;
            r_start_to_next   <= 1'b0;
        end else begin
            r_end_to_previous <= 1'b0;
            r_start_to_next   <= 1'b0;
            if (r_start_to_next)
                r_next_busy <= 1'b1;
            else if (end_from_next)
                r_next_busy <= 1'b0;
            if (start_from_previous && r_state != IDLE)
                r_pending <= 1'b1;
            case (r_state)
                IDLE: if (start_from_previous || r_pending) begin
                    r_pending <= 1'b0;
                    r_state   <= w_next_busy ? WAIT_NEXT : RUN;
                end
                WAIT_NEXT: if (!w_next_busy) r_state <= RUN;
                RUN: if (w_last_elem) begin
                    r_state <= DRAIN;
                    r_drain <= 1'b0;
                end
                DRAIN: if (r_drain) begin
                    r_state           <= DONE;
                    r_end_to_previous <= 1'b1;
                    r_start_to_next   <= 1'b1;
                end else begin
                    r_drain <= 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data returns one cycle after the read, then the write follows accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conv_en      <= 1'b0;
            r_pad_zero     <= 1'b0;
            r_accu_en      <= 1'b0;
            r_acc_ofm_addr <= '0;
            r_acc_valid    <= '0;
            r_relu_en      <= 1'b0;
            r_ofm_we       <= 1'b0;
            r_ofm_addr     <= '0;
            r_ofm_valid    <= '0;
        end else begin
            r_conv_en      <= w_issue;
            r_pad_zero     <= w_issue & w_pad;
            r_accu_en      <= w_issue & w_last_win;
            r_acc_ofm_addr <= w_ofm_addr;
            r_acc_valid    <= w_unit_valid;
            r_relu_en      <= r_accu_en;
            r_ofm_we       <= r_accu_en;
            r_ofm_addr     <= r_accu_en ? r_acc_ofm_addr : '0;
            r_ofm_valid    <= r_accu_en ? r_acc_valid : '0;
        end
    end

    assign busy              = (r_state != IDLE);
    assign end_to_previous   = r_end_to_previous;
    assign start_to_next     = r_start_to_next;
    assign ifm_enable_read   = w_issue & ~w_pad;
    assign ifm_address_read  = (w_issue && !w_pad) ? w_ifm_addr : '0;
    assign wm_enable_read    = w_issue;
    assign wm_address_read   = w_issue ? w_wm_addr : '0;
    assign bm_enable_read    = w_issue & w_first_win;
    assign bm_address_read   = (w_issue && w_first_win) ? w_bm_addr : '0;
    assign pad_zero          = r_pad_zero;
    assign conv_enable       = r_conv_en;
    assign accu_enable       = r_accu_en;
    assign relu_enable       = r_relu_en;
    assign ofm_enable_write  = r_ofm_we;
    assign ofm_address_write = r_ofm_addr;
    assign ofm_unit_valid    = r_ofm_valid;

endmodule

// File: tb/tb_conv_seq_cu.sv
// Directed bench for conv_seq_cu: 5x5x2 input, 3x3 kernel, stride 2, pad 1,
// 20 filters over 8 units, with a queue scoreboard on reads, conv and writes.
module tb_conv_seq_cu;

    localparam int N = 5, D = 2, K = 3, S = 2, P = 1, FILT = 20, U = 8;
    localparam int O = 3, G = 3, EL = D * K * K;
    localparam int RUN_ELEMS  = G * O * O * EL;
    localparam int RUN_WRITES = G * O * O;
    localparam int IFM_AW = $clog2(N * N * D);
    localparam int WM_AW  = $clog2(G * EL);
    localparam int BM_AW  = $clog2(G);
    localparam int OFM_AW = $clog2(G * O * O);

    logic clk = 1'b0;
    logic reset, start_from_previous, end_from_next;
    logic end_to_previous, start_to_next, busy;
    logic ifm_enable_read, pad_zero, wm_enable_read, bm_enable_read;
    logic conv_enable, accu_enable, relu_enable, ofm_enable_write;
    logic [IFM_AW-1:0] ifm_address_read;
    logic [WM_AW-1:0]  wm_address_read;
    logic [BM_AW-1:0]  bm_address_read;
    logic [OFM_AW-1:0] ofm_address_write;
    logic [U-1:0]      ofm_unit_valid;

    conv_seq_cu #(
        .IFM_SIZE(N), .IFM_DEPTH(D), .KERNAL_SIZE(K), .STRIDE(S), .PADDING(P),
        .NUMBER_OF_FILTERS(FILT), .NUMBER_OF_UNITS(U)
    ) dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .end_from_next(end_from_next),
        .end_to_previous(end_to_previous), .start_to_next(start_to_next), .busy(busy),
        .ifm_enable_read(ifm_enable_read), .ifm_address_read(ifm_address_read),
        .pad_zero(pad_zero),
        .wm_enable_read(wm_enable_read), .wm_address_read(wm_address_read),
        .bm_enable_read(bm_enable_read), .bm_address_read(bm_address_read),
        .conv_enable(conv_enable), .accu_enable(accu_enable), .relu_enable(relu_enable),
        .ofm_enable_write(ofm_enable_write), .ofm_address_write(ofm_address_write),
        .ofm_unit_valid(ofm_unit_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ifm_en;
        logic [15:0] ifm_addr;
        logic [15:0] wm_addr;
        logic        bm_en;
        logic [15:0] bm_addr;
        logic        pad;
        logic        last;
    } rd_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] valid;
    } wr_t;

    rd_t q_rd[$];
    rd_t q_cv[$];
    wr_t q_wr[$];

    int n_vec = 0, n_err = 0;
    int n_rd_all = 0, n_rd_run = 0, n_wr_run = 0, n_ep = 0, since_rd = 100;
    int saved_rd, saved_ep;
    logic prev_accu = 1'b0;
    rd_t m_rd, m_cv;
    wr_t m_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected element stream for one full layer pass, straight from the loop nest.
    task automatic push_run();
        rd_t e;
        wr_t w;
        int y, x;
        for (int g = 0; g < G; g++)
            for (int r = 0; r < O; r++)
                for (int c = 0; c < O; c++) begin
                    for (int d = 0; d < D; d++)
                        for (int kr = 0; kr < K; kr++)
                            for (int kc = 0; kc < K; kc++) begin
                                y = r * S + kr - P;
                                x = c * S + kc - P;
                                e.pad      = (y < 0) || (y >= N) || (x < 0) || (x >= N);
                                e.ifm_en   = !e.pad;
                                e.ifm_addr = e.pad ? 16'd0 : 16'(d * N * N + y * N + x);
                                e.wm_addr  = 16'(g * EL + d * K * K + kr * K + kc);
                                e.bm_en    = (d == 0) && (kr == 0) && (kc == 0);
                                e.bm_addr  = e.bm_en ? 16'(g) : 16'd0;
                                e.last     = (d == D - 1) && (kr == K - 1) && (kc == K - 1);
                                q_rd.push_back(e);
                                q_cv.push_back(e);
                            end
                    w.addr  = 16'(g * O * O + r * O + c);
                    w.valid = (g < G - 1) ? 16'hFF : 16'((1 << (FILT - (G - 1) * U)) - 1);
                    q_wr.push_back(w);
                end
    endtask

    function automatic logic any_out();
        return |{end_to_previous, start_to_next, busy, ifm_enable_read, ifm_address_read,
                 pad_zero, wm_enable_read, wm_address_read, bm_enable_read, bm_address_read,
                 conv_enable, accu_enable, relu_enable, ofm_enable_write,
                 ofm_address_write, ofm_unit_valid};
    endfunction

    task automatic wait_stn(input string tag);
        int n;
        n = 0;
        while (start_to_next !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(start_to_next), 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (wm_enable_read) begin
                n_rd_all++;
                n_rd_run++;
                since_rd = 0;
                if (q_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else begin
                    m_rd = q_rd.pop_front();
                    check("ifm_read", ifm_enable_read ? 32'h10000 + 32'(ifm_address_read) : 32'd0,
                          m_rd.ifm_en ? 32'h10000 + 32'(m_rd.ifm_addr) : 32'd0);
                    check("wm_addr", 32'(wm_address_read), 32'(m_rd.wm_addr));
                    check("bm_read", bm_enable_read ? 32'h10000 + 32'(bm_address_read) : 32'd0,
                          m_rd.bm_en ? 32'h10000 + 32'(m_rd.bm_addr) : 32'd0);
                end
            end else begin
                since_rd++;
                if (ifm_enable_read || bm_enable_read) check("rd_stray", 32'd1, 32'd0);
            end
            if (conv_enable) begin
                if (q_cv.size() == 0) check("cv_unexpected", 32'd1, 32'd0);
                else begin
                    m_cv = q_cv.pop_front();
                    check("pad_zero", 32'(pad_zero), 32'(m_cv.pad));
                    check("accu_enable", 32'(accu_enable), 32'(m_cv.last));
                end
            end else if (pad_zero || accu_enable) check("cv_stray", 32'd1, 32'd0);
            if (ofm_enable_write) begin
                n_wr_run++;
                if (q_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    m_wr = q_wr.pop_front();
                    check("ofm_addr", 32'(ofm_address_write), 32'(m_wr.addr));
                    check("unit_valid", 32'(ofm_unit_valid), 32'(m_wr.valid));
                    check("relu_with_write", 32'(relu_enable), 32'd1);
                    check("write_after_accu", 32'(prev_accu), 32'd1);
                end
            end else if (relu_enable) check("relu_stray", 32'd1, 32'd0);
            prev_accu = accu_enable;
            if (end_to_previous) n_ep++;
            if (start_to_next) begin
                // Last read in RUN, two DRAIN cycles, then the DONE pulse.
                check("done_gap", 32'(since_rd), 32'd3);
                check("end_with_start", 32'(end_to_previous), 32'd1);
                check("reads_per_run", 32'(n_rd_run), 32'(RUN_ELEMS));
                check("writes_per_run", 32'(n_wr_run), 32'(RUN_WRITES));
                n_rd_run = 0;
                n_wr_run = 0;
            end else if (end_to_previous) check("ep_stray", 32'd1, 32'd0);
        end
    end

    initial begin
        reset = 1'b0;
        start_from_previous = 1'b0;
        end_from_next = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(any_out()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Run 1, with a second start latched as pending and a third dropped.
        start_from_previous = 1'b1;
        push_run();
        @(negedge clk);
        start_from_previous = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_first_read", 32'(wm_enable_read), 32'd1);
        repeat (10) @(negedge clk);
        start_from_previous = 1'b1;
        push_run();
        @(negedge clk);
        start_from_previous = 1'b0;
        @(negedge clk);
        start_from_previous = 1'b1;
        @(negedge clk);
        start_from_previous = 1'b0;
        wait_stn("run1_done");

        // Pending start must wait for the next layer to release the OFM buffer.
        @(negedge clk);
        saved_rd = n_rd_all;
        repeat (6) @(negedge clk);
        check("wait_next_busy", 32'(busy), 32'd1);
        check("wait_next_hold", 32'(n_rd_all), 32'(saved_rd));
        end_from_next = 1'b1;
        @(negedge clk);
        end_from_next = 1'b0;
        check("resume_next_cycle", 32'(wm_enable_read), 32'd1);
        wait_stn("run2_done");

        // Release coincides with start_to_next: the set wins, next_busy stays 1.
        end_from_next = 1'b1;
        @(negedge clk);
        end_from_next = 1'b0;
        start_from_previous = 1'b1;
        push_run();
        @(negedge clk);
        start_from_previous = 1'b0;
        saved_rd = n_rd_all;
        repeat (5) @(negedge clk);
        check("set_wins_busy", 32'(busy), 32'd1);
        check("set_wins_hold", 32'(n_rd_all), 32'(saved_rd));
        end_from_next = 1'b1;
        @(negedge clk);
        end_from_next = 1'b0;
        check("resume_after_clear", 32'(wm_enable_read), 32'd1);

        // Asynchronous reset mid-run aborts with no handshake pulses.
        repeat (20) @(negedge clk);
        saved_ep = n_ep;
        #3 reset = 1'b0;
        #1 check("reset_async_clear", 32'(any_out()), 32'd0);
        q_rd.delete();
        q_cv.delete();
        q_wr.delete();
        n_rd_run = 0;
        n_wr_run = 0;
        prev_accu = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("no_end_after_reset", 32'(n_ep), 32'(saved_ep));
        check("idle_after_reset", 32'(busy), 32'd0);

        // Fresh start after reset runs immediately (next_busy was cleared).
        start_from_previous = 1'b1;
        push_run();
        @(negedge clk);
        start_from_previous = 1'b0;
        check("fresh_first_read", 32'(wm_enable_read), 32'd1);
        wait_stn("run4_done");
        @(negedge clk);
        check("rd_queue_empty", 32'(q_rd.size()), 32'd0);
        check("cv_queue_empty", 32'(q_cv.size()), 32'd0);
        check("wr_queue_empty", 32'(q_wr.size()), 32'd0);
        check("idle_at_end", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
